// File: rtl/pc_sequencer.sv
// pc_sequencer: FETCH/EXEC program-counter sequencer with jump, branch, halt and PC-range error.
// Optional cycle_count output is enabled by defining PC_SEQ_CYCLE_COUNT_EN.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter logic [15:0] PC_LAST  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] jmp_loc,
    input  logic        cond_true,
    input  logic        ex_busy,
    output logic [15:0] pc,
    output logic        instr_valid,
    output logic        halted,
    output logic        pc_err,
`ifdef PC_SEQ_CYCLE_COUNT_EN
    output logic [15:0] cycle_count,
`endif
    output logic [15:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, instr_count_q, instr_count_d;
    logic        instr_valid_q, halted_q, pc_err_q, pc_err_d;
    logic        is_branch, take;

    assign is_branch = opcode == 4'b1010 || opcode == 4'b1011 || opcode == 4'b1100;
    assign take      = opcode == 4'b0010 || (is_branch && cond_true);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_err_d      = pc_err_q;
        instr_count_d = instr_count_q;
        case (state_q)
            IDLE: begin
                pc_d    = RESET_PC;
                state_d = start ? FETCH : IDLE;
            end
            FETCH: state_d = EXEC;
            EXEC: if (!ex_busy) begin
                instr_count_d = instr_count_q + 16'd1;
                if (opcode == 4'b1110) begin
                    state_d = HALT;
                end else if (take) begin
                    pc_d    = jmp_loc;
                    state_d = FETCH;
                end else if (pc_q == PC_LAST) begin
                    pc_err_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    state_d = FETCH;
                end
            end
            HALT: if (start) begin
                pc_d          = RESET_PC;
                pc_err_d      = 1'b0;
                instr_count_d = '0;
                state_d       = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            pc_err_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= state_d == EXEC;
            halted_q      <= state_d == HALT;
            pc_err_q      <= pc_err_d;
            instr_count_q <= instr_count_d;
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if ((state_q == IDLE || state_q == HALT) && start)
            cycle_count_d = '0;
        else if (state_q == FETCH || state_q == EXEC)
            cycle_count_d = cycle_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_count_q <= '0;
        else        cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`endif

    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign pc_err      = pc_err_q;
    assign instr_count = instr_count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer with a small instruction ROM table.
module tb_pc_sequencer;
    logic        clk = 0, rst_n = 0;
    logic        start = 0, cond_true = 0, ex_busy = 0;
    logic [3:0]  opcode;
    logic [15:0] jmp_loc, pc, instr_count;
    logic        instr_valid, halted, pc_err;
    logic        start1 = 0;
    logic [15:0] pc1, instr_count1;
    logic        instr_valid1, halted1, pc_err1;
`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count, cycle_count1;
`endif
    logic [3:0]  rom_op [0:63];
    logic [15:0] rom_jmp [0:63];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign opcode  = rom_op[pc[5:0]];
    assign jmp_loc = rom_jmp[pc[5:0]];

    pc_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .jmp_loc(jmp_loc),
        .cond_true(cond_true), .ex_busy(ex_busy), .pc(pc), .instr_valid(instr_valid),
        .halted(halted), .pc_err(pc_err),
`ifdef PC_SEQ_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .instr_count(instr_count)
    );

    pc_sequencer #(.PC_LAST(16'd3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .opcode(4'b1111), .jmp_loc(16'd40),
        .cond_true(1'b0), .ex_busy(1'b0), .pc(pc1), .instr_valid(instr_valid1),
        .halted(halted1), .pc_err(pc_err1),
`ifdef PC_SEQ_CYCLE_COUNT_EN
        .cycle_count(cycle_count1),
`endif
        .instr_count(instr_count1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enters in FETCH at exp_pc, leaves in the following FETCH (or HALT).
    task automatic exec_at(input logic [15:0] exp_pc, input logic [15:0] exp_cnt);
        check("fetch_pc", pc, exp_pc);
        check("fetch_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        check("exec_pc", pc, exp_pc);
        check("exec_valid", {15'd0, instr_valid}, 16'd1);
        check("exec_cnt", instr_count, exp_cnt);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_op[i]  = 4'b0111;
            rom_jmp[i] = 16'd0;
        end
        rom_op[5]  = 4'b0010; rom_jmp[5]  = 16'd10;
        rom_op[10] = 4'b1011; rom_jmp[10] = 16'd37;
        rom_op[11] = 4'b1011; rom_jmp[11] = 16'd10;
        rom_op[37] = 4'b1110;

        #2;
        check("rst_pc", pc, 16'd0);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_cnt", instr_count, 16'd0);
        tick();
        rst_n = 1;
        tick();
        check("idle_valid", {15'd0, instr_valid}, 16'd0);
        start = 1;
        tick();
        start = 0;
`ifdef PC_SEQ_CYCLE_COUNT_EN
        check("cc_start", cycle_count, 16'd0);
`endif
        exec_at(16'd0, 16'd0);
        exec_at(16'd1, 16'd1);
        exec_at(16'd2, 16'd2);
        check("seq_cnt3", instr_count, 16'd3);
        exec_at(16'd3, 16'd3);
        check("stall_fetch_pc", pc, 16'd4);
        tick();
        ex_busy = 1;
        start = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 16'd4);
            check("stall_valid", {15'd0, instr_valid}, 16'd1);
            check("stall_cnt", instr_count, 16'd4);
        end
        ex_busy = 0;
        start = 0;
        tick();
        exec_at(16'd5, 16'd5);
        cond_true = 0;
        exec_at(16'd10, 16'd6);
        cond_true = 1;
        exec_at(16'd11, 16'd7);
        exec_at(16'd10, 16'd8);
        cond_true = 0;
        exec_at(16'd37, 16'd9);
        check("halt_halted", {15'd0, halted}, 16'd1);
        check("halt_pc", pc, 16'd37);
        check("halt_cnt", instr_count, 16'd10);
        check("halt_valid", {15'd0, instr_valid}, 16'd0);
        check("halt_err", {15'd0, pc_err}, 16'd0);
        tick();
        tick();
        check("halt_hold_pc", pc, 16'd37);
        check("halt_hold_cnt", instr_count, 16'd10);

        start1 = 1;
        tick();
        start1 = 0;
        for (int i = 0; i < 8; i++) tick();
        check("last_err", {15'd0, pc_err1}, 16'd1);
        check("last_halted", {15'd0, halted1}, 16'd1);
        check("last_pc", pc1, 16'd3);
        check("last_cnt", instr_count1, 16'd4);
        start1 = 1;
        tick();
        start1 = 0;
        check("last_restart_err", {15'd0, pc_err1}, 16'd0);
        check("last_restart_pc", pc1, 16'd0);

        start = 1;
        tick();
        start = 0;
        check("restart_pc", pc, 16'd0);
        check("restart_cnt", instr_count, 16'd0);
        check("restart_halted", {15'd0, halted}, 16'd0);
        exec_at(16'd0, 16'd0);
        tick();
        check("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
        check("pre_rst_pc", pc, 16'd1);
        #2;
        rst_n = 0;
        #1;
        check("arst_pc", pc, 16'd0);
        check("arst_valid", {15'd0, instr_valid}, 16'd0);
        check("arst_cnt", instr_count, 16'd0);
        check("arst_halted", {15'd0, halted}, 16'd0);
        check("arst_err1", {15'd0, pc_err1}, 16'd0);
        tick();
        rst_n = 1;
        tick();
        tick();
        check("post_rst_valid", {15'd0, instr_valid}, 16'd0);
        check("post_rst_pc", pc, 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'd0, is the PC loaded on reset and on every start.
REQ-002 Parameter PC_LAST, default 16'hFFFF, is the highest legal PC for sequential advance.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin/restart program execution; sampled in IDLE and HALT only.
REQ-006 opcode  input  4  opcode of the instruction at pc, from the instruction ROM.
REQ-007 jmp_loc  input  16  jump/branch target for the instruction at pc, from the instruction ROM.
REQ-008 cond_true  input  1  datapath branch condition for the current BNE/BEQ/BLT; valid while ex_busy=0.
REQ-009 ex_busy  input  1  datapath stall; 1 holds the current instruction in EXEC.
REQ-010 pc  output  16  address driven to the instruction ROM.
REQ-011 instr_valid  output  1  1 when the instruction at pc is presented to the datapath for execution.
REQ-012 halted  output  1  1 while in HALT.
REQ-013 pc_err  output  1  sticky; set when sequential advance is attempted from PC_LAST.
REQ-014 instr_count  output  16  retired-instruction count, wraps 16'hFFFF -> 0.

Function
REQ-015 FSM states are exactly IDLE, FETCH, EXEC, HALT; state and all outputs are registered.
REQ-016 IDLE: pc=RESET_PC, instr_valid=0; start=1 -> FETCH, otherwise stay.
REQ-017 FETCH: one ROM-settle cycle, instr_valid=0, pc unchanged; always -> EXEC.
REQ-018 EXEC: instr_valid=1; ex_busy=1 -> stay in EXEC, pc and instr_count held.
REQ-019 EXEC with ex_busy=0 retires the instruction: instr_count+1, next pc chosen per REQ-020..REQ-024.
REQ-020 opcode 4'b1110 (HALT) -> HALT state, pc held at the halt address.
REQ-021 opcode 4'b0010 (JMP) -> pc=jmp_loc, -> FETCH.
REQ-022 opcode 4'b1010/4'b1011/4'b1100 (BNE/BEQ/BLT): cond_true=1 -> pc=jmp_loc, else pc+1; -> FETCH.
REQ-023 All other opcodes, including 4'b1111, -> pc+1, -> FETCH.
REQ-024 A sequential advance with pc==PC_LAST -> pc held, pc_err=1, -> HALT; taken jumps and branches never set pc_err.
REQ-025 Unstalled throughput is one instruction per 2 cycles (FETCH+EXEC).
REQ-026 start asserted in FETCH or EXEC has no effect.
REQ-027 HALT: halted=1, instr_valid=0; start=1 -> pc=RESET_PC, pc_err=0, instr_count=0, -> FETCH.
REQ-028 halted is 0 in every state other than HALT.

Reset
REQ-029 rst_n=0 immediately forces state=IDLE, pc=RESET_PC, instr_valid=0, halted=0, pc_err=0, instr_count=0, regardless of clk.
REQ-030 Reset asserted mid-EXEC discards the in-flight instruction without counting it; after release the block waits for start.

Configuration
REQ-031 Macro PC_SEQ_CYCLE_COUNT_EN, when defined, adds output cycle_count (16 bits): cleared on reset and on start, +1 on every clk edge in FETCH or EXEC, frozen in IDLE/HALT, wraps at 16'hFFFF.
REQ-032 Without PC_SEQ_CYCLE_COUNT_EN, the port and its counter are absent; all other behaviour is identical.

Verification
REQ-033 Reset, start pulse, opcodes 0111 at pc 0..2 with ex_busy=0 -> pc 0,1,2,3 on successive EXEC cycles, instr_count=3, 2 cycles per instruction.
REQ-034 JMP at pc=5 with jmp_loc=10 -> next FETCH at pc=10; BEQ with cond_true=0 -> pc+1; with cond_true=1 and jmp_loc=10 -> pc=10.
REQ-035 ex_busy=1 for 3 cycles in EXEC at pc=4 -> pc=4, instr_valid=1 held, instr_count unchanged until ex_busy=0.
REQ-036 HALT opcode at pc=37 -> halted=1, pc=37, instr_count frozen; start -> pc=0, instr_count=0, FETCH.
REQ-037 PC_LAST=16'd3, ADD at pc=3 -> pc_err=1, halted=1, pc=3; rst_n=0 mid-EXEC -> all outputs at reset values the same cycle.
